// File: rtl/b2_bcd.sv
// Registered 4-bit binary to two-digit BCD converter.
// Double-dabble core feeding a 5-bit output register; one cycle of latency.
module b2_bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] inp,
  output logic [4:0] outp
);

  logic [4:0] result_d;
  logic [4:0] result_q;

  // Shift the binary value in MSB first, adding 3 to the ones digit before each
  // shift whenever it would overflow past 9 once doubled.
  always_comb begin
    result_d = '0;
    for (int i = 3; i >= 0; i--) begin
      if (result_d[3:0] >= 4'd5) begin
        result_d[3:0] = result_d[3:0] + 4'd3;
      end
      result_d = {result_d[3:0], inp[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign outp = result_q;

endmodule

// File: tb/tb_b2_bcd.sv
// Self-checking bench for b2_bcd: directed scenarios plus randomized stimulus
// compared against an arithmetic decimal-digit model.
module tb_b2_bcd;

  logic       clk;
  logic       rst;
  logic [3:0] inp;
  logic [4:0] outp;

  int checks = 0;
  int errors = 0;

  b2_bcd dut (
    .clk  (clk),
    .rst  (rst),
    .inp  (inp),
    .outp (outp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model_bcd(input int n);
    int tens;
    int ones;
    tens = n / 10;
    ones = n % 10;
    return {tens[0], ones[3:0]};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  // Apply one cycle of stimulus, then check the registered result just after the edge.
  task automatic step(input logic r, input logic [3:0] v, input string tag);
    logic [4:0] want;
    rst = r;
    inp = v;
    want = r ? 5'b00000 : model_bcd(int'(v));
    @(posedge clk);
    #1;
    check(tag, outp, want);
    if (!r) begin
      check({tag, "_ones_le9"}, {4'b0, outp[3:0] <= 4'd9}, 5'd1);
      check({tag, "_value"}, 5'(int'(outp[4]) * 10 + int'(outp[3:0])), {1'b0, v});
    end
  endtask

  initial begin
    logic [4:0] held;
    rst = 1'b1;
    inp = 4'hf;

    // Reset dominates even with the largest input
    step(1'b1, 4'hf, "reset0");
    step(1'b1, 4'hf, "reset1");
    step(1'b0, 4'hf, "first_after_reset");

    for (int n = 0; n < 16; n++) begin
      step(1'b0, 4'(n), $sformatf("sweep%0d", n));
    end

    for (int k = 0; k < 4; k++) begin
      step(1'b0, (k % 2 == 0) ? 4'd9 : 4'd10, $sformatf("decade%0d", k));
    end

    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'd12, $sformatf("hold%0d", k));
    end

    step(1'b0, 4'd11, "pre_rst");
    step(1'b1, 4'd13, "mid_rst");
    step(1'b0, 4'd14, "post_rst");

    // Output must not follow inp between edges
    held = outp;
    inp = 4'd3;
    #2;
    check("no_comb_path", outp, held);

    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
